fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-domain controller of the asynchronous FIFO, running entirely on rd_clk. It consumes the Gray write pointer after it has passed through the write-to-read synchronizer. It owns the binary read pointer, the memory read address/enable and the Gray read pointer sent to the write domain. It also produces the registered empty, almost_empty, fill-level, read-valid and underflow indications.

Parameters:
ADDR, 4, address width; FIFO depth = 2^ADDR; pointers are ADDR+1 bits
AE_THRESH, 2, almost_empty asserts when fill level <= AE_THRESH (range 0..2^ADDR)

Ports:
rd_clk  input  1  read-domain clock, rising edge
rst  input  1  asynchronous, active-low reset
rd_en  input  1  read request from consumer
sync_wr_ptr  input  ADDR+1  Gray write pointer, already synchronized to rd_clk
rd_addr  output  ADDR  memory read address (rd_bin[ADDR-1:0])
rd_mem_en  output  1  memory read enable = accepted read (combinational)
gr_rd_ptr  output  ADDR+1  registered Gray read pointer, to wr-domain synchronizer
empty  output  1  registered empty flag
almost_empty  output  1  registered, level <= AE_THRESH
rd_level  output  ADDR+1  registered fill level 0..2^ADDR
rd_valid  output  1  high one cycle after an accepted read; marks memory data valid
underflow  output  1  sticky error: read requested while empty

Behaviour:
- Reset (rst=0, async): rd_bin=0, gr_rd_ptr=0, empty=1, almost_empty=1, rd_level=0, rd_valid=0, underflow=0. Outputs hold reset values while rst is low; the first update happens on the first rd_clk edge after deassertion.
- Accept: rd_inc = rd_en & ~empty; rd_mem_en = rd_inc. Reads while empty are ignored: no pointer move, no rd_valid.
- Next pointer: rd_bin_next = rd_bin + rd_inc, modulo 2^(ADDR+1), natural wrap with no special case.
- Gray encoding: gray(x) = x ^ (x >> 1). gr_rd_ptr <= gray(rd_bin_next). Only one bit changes per cycle.
- Empty: empty <= (gray(rd_bin_next) == sync_wr_ptr). Compare in full ADDR+1-bit Gray, MSB included.
- Empty timing: deasserts the cycle after sync_wr_ptr changes. On the last read it asserts at the same edge that consumes the entry, so no read is accepted past the last entry.
- Level: wr_bin = Gray-to-binary of sync_wr_ptr, computed by MSB-down XOR prefix.
  - rd_level <= (wr_bin - rd_bin_next) mod 2^(ADDR+1).
  - almost_empty <= (that same value <= AE_THRESH).
- The level is pessimistic because of synchronizer lag: it never exceeds the true occupancy and is always <= 2^ADDR.
- Simultaneous events: a new write visible on sync_wr_ptr in the same cycle as an accepted read is handled as a net update. Empty and level are computed from the new sync_wr_ptr and rd_bin_next.
- rd_valid <= rd_inc, i.e. 1-cycle latency matching synchronous memory read data.
- underflow <= underflow | (rd_en & empty). It clears only on reset.
- Mid-operation reset: everything returns to reset values immediately. The peer write domain is reset by the same rst, and behaviour is undefined if only one side resets.
- Registers: rd_bin, gr_rd_ptr, empty, almost_empty, rd_level, rd_valid and underflow are flops. rd_addr and rd_mem_en are derived combinationally.

Test Plan:
- Reset: hold rst=0 with rd_en=1 and sync_wr_ptr=5'b00010 -> empty=1, rd_level=0, gr_rd_ptr=0, rd_valid=0, underflow=0 throughout.
- Fill 3 then drain:
  - Set sync_wr_ptr=5'b00010 (bin 3) -> next edge empty=0, rd_level=3, almost_empty=0 (AE_THRESH=2).
  - rd_en=1 for 3 cycles -> rd_addr 0,1,2; rd_valid high in cycles 2-4; gr_rd_ptr 00001, 00011, 00010.
  - almost_empty asserts after the first read; empty=1 after the third read.
- Underflow: empty FIFO with rd_en=1 for one cycle -> rd_bin unchanged, rd_mem_en=0, rd_valid=0, underflow=1 and it stays 1 after rd_en drops.
- Full level: sync_wr_ptr=gray(16)=5'b11000 with rd_bin=0 -> rd_level=16, empty=0. Reading all 16 -> rd_addr wraps 15->0, gr_rd_ptr=11000, empty=1.
- Wrap-around: run 40 write/read pairs with the write pointer advanced one ahead -> rd_bin wraps 31->0, gr_rd_ptr goes 10000->00000, level stays 1, empty never falsely asserts, each gr_rd_ptr step changes exactly one bit.
- Mid-operation reset: with rd_level=5, pulse rst low between clock edges -> outputs go to reset values immediately without waiting for rd_clk; normal operation resumes after release.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: owns the read pointer, turns the
// synchronized Gray write pointer into empty/almost_empty/level flags.
module fifo_rd_ctrl #(
  parameter int ADDR      = 4,
  parameter int AE_THRESH = 2
) (
  input  logic            rd_clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [ADDR:0]   sync_wr_ptr,
  output logic [ADDR-1:0] rd_addr,
  output logic            rd_mem_en,
  output logic [ADDR:0]   gr_rd_ptr,
  output logic            empty,
  output logic            almost_empty,
  output logic [ADDR:0]   rd_level,
  output logic            rd_valid,
  output logic            underflow
);

  localparam logic [ADDR:0] AE_LVL = (ADDR+1)'(AE_THRESH);

  logic [ADDR:0] rd_bin, rd_bin_next, gr_next, wr_bin, level_next;
  logic          rd_inc;

  always_comb begin
    rd_inc      = rd_en & ~empty;
    rd_bin_next = rd_bin + {{ADDR{1'b0}}, rd_inc};
    gr_next     = rd_bin_next ^ (rd_bin_next >> 1);
    // Gray->binary: bit i is the XOR of all Gray bits from MSB down to i.
    wr_bin      = '0;
    for (int i = 0; i <= ADDR; i++) wr_bin[i] = ^(sync_wr_ptr >> i);
    level_next  = wr_bin - rd_bin_next;
  end

  assign rd_addr   = rd_bin[ADDR-1:0];
  assign rd_mem_en = rd_inc;

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      rd_bin       <= '0;
      gr_rd_ptr    <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rd_bin       <= rd_bin_next;
      gr_rd_ptr    <= gr_next;
      // Flags use the post-read pointer so the last read closes the FIFO at once.
      empty        <= (gr_next == sync_wr_ptr);
      almost_empty <= (level_next <= AE_LVL);
      rd_level     <= level_next;
      rd_valid     <= rd_inc;
      underflow    <= underflow | (rd_en & empty);
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus random traffic against a
// count-based occupancy model.
module tb_fifo_rd_ctrl;
  localparam int ADDR = 4;
  localparam int AE   = 2;

  logic            rd_clk = 1'b0;
  logic            rst;
  logic            rd_en;
  logic [ADDR:0]   sync_wr_ptr;
  logic [ADDR-1:0] rd_addr;
  logic            rd_mem_en;
  logic [ADDR:0]   gr_rd_ptr;
  logic            empty, almost_empty;
  logic [ADDR:0]   rd_level;
  logic            rd_valid, underflow;

  fifo_rd_ctrl #(.ADDR(ADDR), .AE_THRESH(AE)) dut (
    .rd_clk(rd_clk), .rst(rst), .rd_en(rd_en), .sync_wr_ptr(sync_wr_ptr),
    .rd_addr(rd_addr), .rd_mem_en(rd_mem_en), .gr_rd_ptr(gr_rd_ptr),
    .empty(empty), .almost_empty(almost_empty), .rd_level(rd_level),
    .rd_valid(rd_valid), .underflow(underflow)
  );

  always #5 rd_clk = ~rd_clk;

  // Model: total entries read / total writes visible, as plain integers.
  int m_rd, m_wr, m_level;
  logic m_empty, m_ae, m_valid, m_uf;
  int n_vec = 0, n_err = 0;

  function automatic logic [ADDR:0] gray(input int x);
    logic [ADDR:0] b;
    b = x[ADDR:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1; m_valid = 1'b0; m_uf = 1'b0;
  endtask

  task automatic check_regs(input string ph);
    chk({ph, ".gr_rd_ptr"},    32'(gr_rd_ptr),    32'(gray(m_rd)));
    chk({ph, ".empty"},        32'(empty),        32'(m_empty));
    chk({ph, ".almost_empty"}, 32'(almost_empty), 32'(m_ae));
    chk({ph, ".rd_level"},     32'(rd_level),     32'(m_level));
    chk({ph, ".rd_valid"},     32'(rd_valid),     32'(m_valid));
    chk({ph, ".underflow"},    32'(underflow),    32'(m_uf));
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check flops.
  task automatic step(input logic ren, input int wr_cnt, input string ph);
    logic acc;
    @(negedge rd_clk);
    rd_en = ren; m_wr = wr_cnt; sync_wr_ptr = gray(wr_cnt);
    acc = ren && !m_empty;
    #1;
    chk({ph, ".rd_addr"},   32'(rd_addr),   32'(m_rd % (1 << ADDR)));
    chk({ph, ".rd_mem_en"}, 32'(rd_mem_en), 32'(acc));
    @(posedge rd_clk);
    m_uf    = m_uf | (ren && m_empty);
    m_rd    = m_rd + int'(acc);
    m_level = m_wr - m_rd;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= AE);
    m_valid = acc;
    #1;
    check_regs(ph);
  endtask

  // Async reset pulse between edges; outputs must clear without a clock edge.
  task automatic rst_pulse(input string ph);
    @(negedge rd_clk);
    #1;
    rst = 1'b0; rd_en = 1'b0; m_wr = 0; sync_wr_ptr = '0;
    #1;
    model_reset();
    check_regs(ph);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [ADDR:0] prev_gr;
    int wr_nxt;
    // Reset held with a read request and a non-zero write pointer.
    rst = 1'b0; rd_en = 1'b1; m_wr = 3; sync_wr_ptr = 5'b00010;
    model_reset();
    repeat (3) begin
      @(negedge rd_clk);
      check_regs("reset");
      chk("reset.rd_mem_en", 32'(rd_mem_en), 32'd0);
    end
    rd_en = 1'b0; rst = 1'b1;

    // Fill 3, drain 3, then underflow.
    step(1'b0, 3, "fill3");
    for (int i = 0; i < 3; i++) step(1'b1, 3, "drain");
    step(1'b0, 3, "drained");
    step(1'b1, 3, "uflow");
    step(1'b0, 3, "uflow_hold");
    step(1'b0, 3, "uflow_hold2");

    // Full level from rd_bin=0, then read all 16 entries.
    rst_pulse("rst_full");
    step(1'b0, 16, "full");
    for (int i = 0; i < 16; i++) step(1'b1, 16, "rd_full");
    step(1'b1, 16, "full_empty");

    // Wrap-around: write one ahead, read every cycle, level stays at 1.
    step(1'b0, 17, "wrap_pre");
    for (int i = 0; i < 40; i++) begin
      prev_gr = gr_rd_ptr;
      step(1'b1, m_rd + 2, "wrap");
      chk("wrap.onebit", 32'($countones(prev_gr ^ gr_rd_ptr)), 32'd1);
    end

    // Random traffic, write pointer advances at most one step per cycle.
    for (int i = 0; i < 300; i++) begin
      wr_nxt = m_wr;
      if ($urandom_range(0, 1) == 1 && (m_wr - m_rd) < (1 << ADDR)) wr_nxt = m_wr + 1;
      step(1'($urandom_range(0, 1)), wr_nxt, "rand");
    end

    // Mid-operation reset with level 5, then resume.
    rst_pulse("rst_mid0");
    step(1'b0, 5, "lvl5");
    rst_pulse("rst_mid");
    step(1'b0, 2, "resume");
    step(1'b1, 2, "resume_rd");
    step(1'b1, 3, "resume_rd2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
